// File: rtl/vehicle_pkg.sv
// vehicle_pkg: shared constants and FSM state encoding for vehicle-board blocks.
package vehicle_pkg;
    localparam int SYS_CLK_HZ = 50_000_000;
    localparam int CNT_W_DEF  = 16;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer on an async input plus rise/fall detection.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("sync_edge_det: STAGES must be 2..4");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= s;
        end
    end

    assign s    = sync[STAGES-1];
    assign rise = s & ~prev;
    assign fall = ~s & prev;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow input in clk cycles.
// Define PERIOD_METER_AVG_EN to report the average of four consecutive measurements.
module period_meter
    import vehicle_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, hcnt, high_lat;
    logic             high_phase, rise, fall, sync_unused;
    logic             arm_rise, meas_rise, tmo, clr;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sig_in),
        .s    (sync_unused),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = !enable                           ? IDLE    :
                   (state == IDLE)                   ? ARM     :
                   (state != ARM && state != MEASURE) ? IDLE    :
                   rise                              ? MEASURE :
                   tmo                               ? ARM     : state;
    end

    // A rise on the same cycle as cnt reaching CNT_MAX is a valid measurement, not a timeout.
    always_comb begin
        arm_rise  = enable && state == ARM && rise;
        meas_rise = enable && state == MEASURE && rise;
        tmo       = enable && state == MEASURE && !rise && cnt == CNT_MAX;
        clr       = !enable || state == IDLE || tmo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            hcnt       <= '0;
            high_lat   <= '0;
            high_phase <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (tmo) timeout <= 1'b1;
            else if (meas_rise) timeout <= 1'b0;
            if (clr) begin
                cnt        <= '0;
                hcnt       <= '0;
                high_lat   <= '0;
                high_phase <= 1'b0;
            end else if (arm_rise || meas_rise) begin
                cnt        <= CNT_W'(1);
                hcnt       <= CNT_W'(1);
                high_phase <= 1'b1;
            end else if (state == MEASURE) begin
                cnt <= cnt + 1'b1;
                if (high_phase) hcnt <= hcnt + 1'b1;
                if (fall && high_phase) begin
                    high_lat   <= hcnt;
                    high_phase <= 1'b0;
                end
            end
        end
    end

`ifdef PERIOD_METER_AVG_EN
    logic [1:0]       smp;
    logic [CNT_W+1:0] acc_p, acc_h, sum_p, sum_h;

    always_comb begin
        sum_p = acc_p + {2'b00, cnt};
        sum_h = acc_h + {2'b00, high_lat};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp       <= '0;
            acc_p     <= '0;
            acc_h     <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= meas_rise && smp == 2'd3;
            if (!enable || tmo) begin
                smp   <= '0;
                acc_p <= '0;
                acc_h <= '0;
            end else if (meas_rise) begin
                smp   <= smp + 2'd1;
                acc_p <= (smp == 2'd3) ? '0 : sum_p;
                acc_h <= (smp == 2'd3) ? '0 : sum_h;
                if (smp == 2'd3) begin
                    period    <= sum_p[CNT_W+1:2];
                    high_time <= sum_h[CNT_W+1:2];
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= meas_rise;
            if (meas_rise) begin
                period    <= cnt;
                high_time <= high_lat;
            end
        end
    end
`endif
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: random and directed square waves checked against a timestamp model.
module tb_period_meter;
    localparam int W   = 8;
    localparam int LIM = 255;

    logic         clk = 1'b0, reset = 1'b1, enable = 1'b0, sig_in = 1'b0;
    logic [W-1:0] period, high_time;
    logic         valid, timeout;

    int total = 0, bad = 0, cyc = 0;
    int exp_p[$], exp_h[$];
    bit armed = 1'b0;
    int last_rise = 0, last_high = 0;
    logic v_prev = 1'b0;

    period_meter #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .timeout  (timeout)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a rise while armed and within LIM cycles of the last one yields one result.
    task automatic set_sig(input bit v);
        sig_in = v;
        if (v) begin
            if (armed && cyc - last_rise <= LIM) begin
                exp_p.push_back(cyc - last_rise);
                exp_h.push_back(last_high);
            end
            armed     = 1'b1;
            last_rise = cyc;
        end else if (armed) begin
            last_high = cyc - last_rise;
        end
    endtask

    task automatic wave(input int h, input int l);
        set_sig(1'b1);
        tick(h);
        set_sig(1'b0);
        tick(l);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            v_prev = 1'b0;
        end else begin
            if (valid) begin
                chk("spurious_valid", 32'(exp_p.size() == 0), 0);
                chk("valid_width", 32'(v_prev), 0);
                if (exp_p.size() != 0) begin
                    chk("period", 32'(period), exp_p.pop_front());
                    chk("high_time", 32'(high_time), exp_h.pop_front());
                end
            end
            v_prev = valid;
        end
    end

    initial begin
        #25;
        chk("rst_period", 32'(period), 0);
        chk("rst_high", 32'(high_time), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        tick(1);
        reset  = 1'b0;
        enable = 1'b1;
        tick(5);
        repeat (5) wave(51, 51);
        repeat (4) wave(25, 75);
        repeat (20) wave($urandom_range(120, 3), $urandom_range(120, 3));
        wave(100, 155);
        wave(50, 50);
        chk("no_timeout_at_255", 32'(timeout), 0);
        tick(300);
        chk("timeout_set", 32'(timeout), 1);
        wave(40, 40);
        chk("timeout_held_on_arm", 32'(timeout), 1);
        repeat (2) wave(40, 40);
        chk("timeout_cleared", 32'(timeout), 0);
        set_sig(1'b1);
        tick(30);
        set_sig(1'b0);
        tick(10);
        enable = 1'b0;
        armed  = 1'b0;
        tick(2);
        chk("period_held", 32'(period), 80);
        chk("high_held", 32'(high_time), 40);
        tick(20);
        enable = 1'b1;
        tick(5);
        repeat (3) wave(30, 30);
        repeat (2) wave(60, 60);
        set_sig(1'b1);
        tick(20);
        reset = 1'b1;
        #1;
        chk("midrst_period", 32'(period), 0);
        chk("midrst_high", 32'(high_time), 0);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_timeout", 32'(timeout), 0);
        sig_in = 1'b0;
        armed  = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(5);
        repeat (3) wave(45, 45);
        tick(10);
        chk("pending_results", 32'(exp_p.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
